// File: rtl/hybrid16_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module : hybrid16_addsub_pkg
// Brief  : Shared constants and overflow helper for the 16-bit CLA add/sub.
// Rev    : 1.0  initial release
// ============================================================================
package hybrid16_addsub_pkg;

    localparam int WIDTH   = 16;
    localparam int BLK_W   = 4;
    localparam int NUM_BLK = WIDTH / BLK_W;

    // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
    function automatic logic ovf_calc(input logic c_in_msb, input logic c_out_msb);
        return c_in_msb ^ c_out_msb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hybrid16_addsub_if.sv
`default_nettype none
// ============================================================================
// Module : hybrid16_addsub_if
// Brief  : Operand/result bundle for hybrid16_addsub (no handshake).
// Rev    : 1.0  initial release
// ============================================================================
interface hybrid16_addsub_if;

    logic [hybrid16_addsub_pkg::WIDTH-1:0] a;
    logic [hybrid16_addsub_pkg::WIDTH-1:0] b;
    logic                                  sub;
    logic [hybrid16_addsub_pkg::WIDTH-1:0] c;
    logic                                  ovf;

    modport master (output a, output b, output sub, input c, input ovf);
    modport slave  (input a, input b, input sub, output c, output ovf);

endinterface
`default_nettype wire

// File: rtl/hybrid16_addsub_cla4.sv
`default_nettype none
// ============================================================================
// Module : cla4
// Brief  : 4-bit fully look-ahead adder block; also exposes carry into bit 3.
// Rev    : 1.0  initial release
// ============================================================================
module cla4 (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic [3:0]      s,
    output logic            cout,
    output logic            c3
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_cy;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum-of-products of g/p and cin; no ripple inside the block.
    assign w_cy[0] = cin;
    assign w_cy[1] = w_g[0] | (w_p[0] & cin);
    assign w_cy[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_cy[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_cy[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_cy[3:0];
    assign cout = w_cy[4];
    assign c3   = w_cy[3];

endmodule
`default_nettype wire

// File: rtl/hybrid16_addsub.sv
`default_nettype none
// ============================================================================
// Module : hybrid16_addsub
// Brief  : 16-bit registered add/subtract, four CLA blocks rippled, signed ovf.
// Rev    : 1.0  initial release
// ============================================================================
module hybrid16_addsub
    import hybrid16_addsub_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    hybrid16_addsub_if.slave   bus
);

    logic [WIDTH-1:0]   w_bx;
    logic [WIDTH-1:0]   w_sum;
    logic [NUM_BLK:0]   w_carry;
    logic [NUM_BLK-1:0] w_c3;

    // Subtraction is a + ~b + 1: invert b here, inject the +1 as block 0 carry-in.
    assign w_bx       = bus.b ^ {WIDTH{bus.sub}};
    assign w_carry[0] = bus.sub;

    genvar k;
    generate
        for (k = 0; k < NUM_BLK; k++) begin : g_blk
            cla4 u_cla (
                .a    (bus.a[k*BLK_W +: BLK_W]),
                .b    (w_bx[k*BLK_W +: BLK_W]),
                .cin  (w_carry[k]),
                .s    (w_sum[k*BLK_W +: BLK_W]),
                .cout (w_carry[k+1]),
                .c3   (w_c3[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.c   <= '0;
            bus.ovf <= 1'b0;
        end else begin
            bus.c   <= w_sum;
            bus.ovf <= ovf_calc(w_c3[NUM_BLK-1], w_carry[NUM_BLK]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hybrid16_addsub.sv
`default_nettype none
// ============================================================================
// Module : tb_hybrid16_addsub
// Brief  : Directed and random self-checking bench for hybrid16_addsub.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hybrid16_addsub;

    typedef struct {
        logic [15:0] c;
        logic        ovf;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    hybrid16_addsub_if bus ();

    hybrid16_addsub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic ms, input logic mrst, input string tag);
        exp_t e;
        e.tag = tag;
        if (!mrst) begin
            e.c   = 16'h0000;
            e.ovf = 1'b0;
        end else if (ms) begin
            e.c   = ma - mb;
            e.ovf = (ma[15] != mb[15]) && (e.c[15] != ma[15]);
        end else begin
            e.c   = ma + mb;
            e.ovf = (ma[15] == mb[15]) && (e.c[15] != ma[15]);
        end
        return e;
    endfunction

    // One operation per cycle: drive at negedge, check just after the next posedge.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic trst, input string tag);
        exp_t e;
        @(negedge clk);
        bus.a   = ta;
        bus.b   = tb_v;
        bus.sub = ts;
        rst_n   = trst;
        sb.push_back(model(ta, tb_v, ts, trst, tag));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        assert (bus.c === e.c) else begin
            n_fail++;
            $error("FAIL %s c: got %h expected %h", e.tag, bus.c, e.c);
        end
        n_checks++;
        assert (bus.ovf === e.ovf) else begin
            n_fail++;
            $error("FAIL %s ovf: got %b expected %b", e.tag, bus.ovf, e.ovf);
        end
    endtask

    // Fixed expectations from the datasheet-style vectors, independent of the model.
    task automatic check_const(input logic [15:0] ec, input logic eovf, input string tag);
        n_checks++;
        assert (bus.c === ec) else begin
            n_fail++;
            $error("FAIL %s const c: got %h expected %h", tag, bus.c, ec);
        end
        n_checks++;
        assert (bus.ovf === eovf) else begin
            n_fail++;
            $error("FAIL %s const ovf: got %b expected %b", tag, bus.ovf, eovf);
        end
    endtask

    initial begin
        bus.a   = 16'h0;
        bus.b   = 16'h0;
        bus.sub = 1'b0;

        step(16'h1234, 16'h4321, 1'b0, 1'b0, "reset");
        check_const(16'h0000, 1'b0, "reset");

        step(16'hB5EA, 16'h250B, 1'b0, 1'b1, "case1");
        check_const(16'hDAF5, 1'b0, "case1");
        step(16'h0099, 16'hFF09, 1'b0, 1'b1, "case2");
        check_const(16'hFFA2, 1'b0, "case2");
        step(16'hB5EA, 16'hFFFA, 1'b1, 1'b1, "case3");
        check_const(16'hB5F0, 1'b0, "case3");
        step(16'h0100, 16'h015E, 1'b1, 1'b1, "case4");
        check_const(16'hFFA2, 1'b0, "case4");
        step(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, "case5a");
        check_const(16'hFFFE, 1'b1, "case5a");
        step(16'h8000, 16'h0001, 1'b1, 1'b1, "case5b");
        check_const(16'h7FFF, 1'b1, "case5b");
        step(16'h0000, 16'h8000, 1'b1, 1'b1, "zero_minus_min");
        check_const(16'h8000, 1'b1, "zero_minus_min");
        step(16'hFFFF, 16'h0001, 1'b0, 1'b1, "ffff_plus_1");
        check_const(16'h0000, 1'b0, "ffff_plus_1");

        step(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, "reset_discard");
        check_const(16'h0000, 1'b0, "reset_discard");
        step(16'hB5EA, 16'h250B, 1'b0, 1'b1, "pipe1");
        check_const(16'hDAF5, 1'b0, "pipe1");
        step(16'h0099, 16'hFF09, 1'b0, 1'b1, "pipe2");
        check_const(16'hFFA2, 1'b0, "pipe2");

        for (int i = 0; i < 10000; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
